// File: rtl/mips_ctrl_alu_mem.sv
// mips_ctrl_alu_mem: ID decoder, EX ALU and MEM data RAM for the
// 5-stage MIPS pipeline. Three independent functions in one block.
//
// Ports:
//   clk, rst          : clock; synchronous active-high reset (clears RAM)
//   op, funct, mf     : instruction fields [31:26], [5:0], [25:21]
//   ctr_aluop, ctr    : decoded ALU op and 19-bit control-flag bus
//   alu_x, alu_y      : ALU operands (shift amount is alu_y[4:0])
//   alu_op            : ALU operation select
//   alu_r1, alu_r2    : primary / secondary (MUL hi, DIV rem) result
//   alu_eq            : alu_x == alu_y, independent of alu_op
//   ram_addr, ram_din : RAM word address and write data
//   ram_we            : RAM write enable
//   ram_dout          : asynchronous RAM read data
//
// Build option: define ALU_MULDIV_EN to implement ALU ops 3 (MUL)
// and 4 (DIV); otherwise both return zero and no mul/div is built.

module mips_ctrl_alu_mem #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        op,
   input  logic [5:0]        funct,
   input  logic [4:0]        mf,
   output logic [3:0]        ctr_aluop,
   output logic [18:0]       ctr,
   input  logic [DATA_W-1:0] alu_x,
   input  logic [DATA_W-1:0] alu_y,
   input  logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_r1,
   output logic [DATA_W-1:0] alu_r2,
   output logic              alu_eq,
   input  logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_din,
   input  logic              ram_we,
   output logic [DATA_W-1:0] ram_dout
);

   localparam int C_DST  = 0;
   localparam int C_WE   = 1;
   localparam int C_BR   = 2;
   localparam int C_JMP  = 3;
   localparam int C_MWE  = 4;
   localparam int C_M2R  = 5;
   localparam int C_SRC  = 6;
   localparam int C_SH   = 7;
   localparam int C_BEQ  = 8;
   localparam int C_BLE  = 9;
   localparam int C_JR   = 10;
   localparam int C_JAL  = 11;
   localparam int C_SYS  = 12;
   localparam int C_SHV  = 13;
   localparam int C_LUI  = 14;
   localparam int C_SHF  = 15;
   localparam int C_ERET = 16;
   localparam int C_MFC  = 17;
   localparam int C_MTC  = 18;

   // ---------------- decoder ----------------
   always_comb begin
      ctr       = '0;
      ctr_aluop = '0;
      unique case (op)
         6'h00: begin
            unique case (funct)
               6'h00, 6'h04: begin
                  ctr_aluop = 4'd0;
                  ctr[C_WE]  = 1'b1;
                  ctr[C_DST] = 1'b1;
                  ctr[C_SH]  = 1'b1;
                  ctr[C_SHV] = funct[2];
               end
               6'h02, 6'h06: begin
                  ctr_aluop = 4'd2;
                  ctr[C_WE]  = 1'b1;
                  ctr[C_DST] = 1'b1;
                  ctr[C_SH]  = 1'b1;
                  ctr[C_SHV] = funct[2];
               end
               6'h03, 6'h07: begin
                  ctr_aluop = 4'd1;
                  ctr[C_WE]  = 1'b1;
                  ctr[C_DST] = 1'b1;
                  ctr[C_SH]  = 1'b1;
                  ctr[C_SHV] = funct[2];
               end
               6'h08: ctr[C_JR]  = 1'b1;
               6'h0C: ctr[C_SYS] = 1'b1;
               6'h20, 6'h21: begin
                  ctr_aluop = 4'd5;
                  ctr[C_WE]  = 1'b1;
                  ctr[C_DST] = 1'b1;
               end
               6'h22, 6'h23: begin
                  ctr_aluop = 4'd6;
                  ctr[C_WE]  = 1'b1;
                  ctr[C_DST] = 1'b1;
               end
               6'h24: begin
                  ctr_aluop = 4'd7;
                  ctr[C_WE]  = 1'b1;
                  ctr[C_DST] = 1'b1;
               end
               6'h25: begin
                  ctr_aluop = 4'd8;
                  ctr[C_WE]  = 1'b1;
                  ctr[C_DST] = 1'b1;
               end
               6'h26: begin
                  ctr_aluop = 4'd9;
                  ctr[C_WE]  = 1'b1;
                  ctr[C_DST] = 1'b1;
               end
               6'h27: begin
                  ctr_aluop = 4'd10;
                  ctr[C_WE]  = 1'b1;
                  ctr[C_DST] = 1'b1;
               end
               6'h2A: begin
                  ctr_aluop = 4'd11;
                  ctr[C_WE]  = 1'b1;
                  ctr[C_DST] = 1'b1;
               end
               6'h2B: begin
                  ctr_aluop = 4'd12;
                  ctr[C_WE]  = 1'b1;
                  ctr[C_DST] = 1'b1;
               end
               default: ;
            endcase
         end
         6'h02: ctr[C_JMP] = 1'b1;
         6'h03: begin
            ctr[C_JMP] = 1'b1;
            ctr[C_JAL] = 1'b1;
            ctr[C_WE]  = 1'b1;
         end
         6'h04: begin
            ctr_aluop = 4'd6;
            ctr[C_BR]  = 1'b1;
            ctr[C_BEQ] = 1'b1;
         end
         6'h05: begin
            ctr_aluop = 4'd6;
            ctr[C_BR]  = 1'b1;
         end
         6'h06: begin
            ctr[C_BR]  = 1'b1;
            ctr[C_BLE] = 1'b1;
         end
         6'h08, 6'h09: begin
            ctr_aluop = 4'd5;
            ctr[C_SRC] = 1'b1;
            ctr[C_WE]  = 1'b1;
         end
         6'h0A: begin
            ctr_aluop = 4'd11;
            ctr[C_SRC] = 1'b1;
            ctr[C_WE]  = 1'b1;
         end
         6'h0B: begin
            ctr_aluop = 4'd12;
            ctr[C_SRC] = 1'b1;
            ctr[C_WE]  = 1'b1;
         end
         6'h0C: begin
            ctr_aluop = 4'd7;
            ctr[C_SRC] = 1'b1;
            ctr[C_WE]  = 1'b1;
         end
         6'h0D: begin
            ctr_aluop = 4'd8;
            ctr[C_SRC] = 1'b1;
            ctr[C_WE]  = 1'b1;
         end
         6'h0E: begin
            ctr_aluop = 4'd9;
            ctr[C_SRC] = 1'b1;
            ctr[C_WE]  = 1'b1;
         end
         6'h0F: begin
            ctr[C_LUI] = 1'b1;
            ctr[C_WE]  = 1'b1;
         end
         6'h10: begin
            // mfc0 writes rt, so rf_dst stays 0
            if (mf == 5'h00) begin
               ctr[C_MFC] = 1'b1;
               ctr[C_WE]  = 1'b1;
            end else if (mf == 5'h04) begin
               ctr[C_MTC] = 1'b1;
            end else if (mf == 5'h10 &&
                         funct == 6'h18) begin
               ctr[C_ERET] = 1'b1;
            end
         end
         6'h23: begin
            ctr_aluop = 4'd5;
            ctr[C_SRC] = 1'b1;
            ctr[C_M2R] = 1'b1;
            ctr[C_WE]  = 1'b1;
         end
         6'h2B: begin
            ctr_aluop = 4'd5;
            ctr[C_SRC] = 1'b1;
            ctr[C_MWE] = 1'b1;
         end
         6'h29: begin
            ctr_aluop = 4'd5;
            ctr[C_SRC] = 1'b1;
            ctr[C_MWE] = 1'b1;
            ctr[C_SHF] = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------- ALU ----------------
   logic [4:0] sh;
   assign sh     = alu_y[4:0];
   assign alu_eq = (alu_x == alu_y);

`ifdef ALU_MULDIV_EN
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   ax, ay, uq, ur;
   logic [DATA_W-1:0]   quo, rem;
   logic                y_zero;

   assign prod = $signed({{DATA_W{alu_x[DATA_W-1]}}, alu_x})
               * $signed({{DATA_W{alu_y[DATA_W-1]}}, alu_y});

   // Sign-magnitude division: avoids the INT_MIN / -1 overflow
   // case of a native signed divide and truncates toward zero.
   assign y_zero = (alu_y == '0);
   assign ax  = alu_x[DATA_W-1] ? -alu_x : alu_x;
   assign ay  = alu_y[DATA_W-1] ? -alu_y : alu_y;
   assign uq  = y_zero ? '0 : ax / ay;
   assign ur  = y_zero ? '0 : ax % ay;
   assign quo = (alu_x[DATA_W-1] ^ alu_y[DATA_W-1])
              ? -uq : uq;
   assign rem = alu_x[DATA_W-1] ? -ur : ur;
`endif

   always_comb begin
      alu_r1 = '0;
      alu_r2 = '0;
      case (alu_op)
         4'd0: alu_r1 = alu_x << sh;
         4'd1: alu_r1 = $unsigned($signed(alu_x) >>> sh);
         4'd2: alu_r1 = alu_x >> sh;
`ifdef ALU_MULDIV_EN
         4'd3: begin
            alu_r1 = prod[DATA_W-1:0];
            alu_r2 = prod[2*DATA_W-1:DATA_W];
         end
         4'd4: begin
            alu_r1 = quo;
            alu_r2 = rem;
         end
`endif
         4'd5:  alu_r1 = alu_x + alu_y;
         4'd6:  alu_r1 = alu_x - alu_y;
         4'd7:  alu_r1 = alu_x & alu_y;
         4'd8:  alu_r1 = alu_x | alu_y;
         4'd9:  alu_r1 = alu_x ^ alu_y;
         4'd10: alu_r1 = ~(alu_x | alu_y);
         4'd11: alu_r1 = {{(DATA_W-1){1'b0}},
                          $signed(alu_x) < $signed(alu_y)};
         4'd12: alu_r1 = {{(DATA_W-1){1'b0}},
                          alu_x < alu_y};
         default: ;
      endcase
   end

   // ---------------- data RAM ----------------
   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Reset wins over a same-cycle write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**ADDR_W; i++)
            mem[i] <= '0;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_din;
      end
   end

   assign ram_dout = mem[ram_addr];

endmodule

// File: tb/tb_mips_ctrl_alu_mem.sv
// tb_mips_ctrl_alu_mem: random + directed self-check of the decoder,
// ALU and data RAM of mips_ctrl_alu_mem against a behavioural model.

module tb_mips_ctrl_alu_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  op, funct;
   logic [4:0]  mf;
   logic [3:0]  ctr_aluop;
   logic [18:0] ctr;
   logic [31:0] alu_x, alu_y, alu_r1, alu_r2;
   logic [3:0]  alu_op;
   logic        alu_eq;
   logic [9:0]  ram_addr;
   logic [31:0] ram_din, ram_dout;
   logic        ram_we;

   int errs   = 0;
   int checks = 0;

   logic [31:0] mdl [1024];

   always #5 clk = ~clk;

   mips_ctrl_alu_mem dut (
      .clk      (clk),
      .rst      (rst),
      .op       (op),
      .funct    (funct),
      .mf       (mf),
      .ctr_aluop(ctr_aluop),
      .ctr      (ctr),
      .alu_x    (alu_x),
      .alu_y    (alu_y),
      .alu_op   (alu_op),
      .alu_r1   (alu_r1),
      .alu_r2   (alu_r2),
      .alu_eq   (alu_eq),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_we   (ram_we),
      .ram_dout (ram_dout)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h",
                  tag, got, exp);
      end
   endtask

   // flag masks named after their meaning
   localparam int DST = 1 << 0,  RW  = 1 << 1;
   localparam int BR  = 1 << 2,  JP  = 1 << 3;
   localparam int MW  = 1 << 4,  M2R = 1 << 5;
   localparam int SRC = 1 << 6,  SH  = 1 << 7;
   localparam int BEQ = 1 << 8,  BLE = 1 << 9;
   localparam int JR  = 1 << 10, JAL = 1 << 11;
   localparam int SYS = 1 << 12, SV  = 1 << 13;
   localparam int LI  = 1 << 14, SHF = 1 << 15;
   localparam int ERT = 1 << 16, MFC = 1 << 17;
   localparam int MTC = 1 << 18;

   // returns {aluop, ctr}
   function automatic logic [22:0] ref_dec(
      input logic [5:0] o, input logic [5:0] f,
      input logic [4:0] m);
      int c = 0;
      int a = 0;
      int rt = RW | DST;
      if (o == 0) begin
         case (f)
            6'h00: begin a = 0; c = rt | SH; end
            6'h02: begin a = 2; c = rt | SH; end
            6'h03: begin a = 1; c = rt | SH; end
            6'h04: begin a = 0; c = rt | SH | SV; end
            6'h06: begin a = 2; c = rt | SH | SV; end
            6'h07: begin a = 1; c = rt | SH | SV; end
            6'h08: c = JR;
            6'h0C: c = SYS;
            6'h20, 6'h21: begin a = 5; c = rt; end
            6'h22, 6'h23: begin a = 6; c = rt; end
            6'h24: begin a = 7;  c = rt; end
            6'h25: begin a = 8;  c = rt; end
            6'h26: begin a = 9;  c = rt; end
            6'h27: begin a = 10; c = rt; end
            6'h2A: begin a = 11; c = rt; end
            6'h2B: begin a = 12; c = rt; end
            default: ;
         endcase
      end else begin
         case (o)
            6'h02: c = JP;
            6'h03: c = JP | JAL | RW;
            6'h04: begin a = 6; c = BR | BEQ; end
            6'h05: begin a = 6; c = BR; end
            6'h06: c = BR | BLE;
            6'h08, 6'h09: begin a = 5; c = SRC | RW; end
            6'h0A: begin a = 11; c = SRC | RW; end
            6'h0B: begin a = 12; c = SRC | RW; end
            6'h0C: begin a = 7;  c = SRC | RW; end
            6'h0D: begin a = 8;  c = SRC | RW; end
            6'h0E: begin a = 9;  c = SRC | RW; end
            6'h0F: c = LI | RW;
            6'h23: begin a = 5; c = SRC | M2R | RW; end
            6'h2B: begin a = 5; c = SRC | MW; end
            6'h29: begin a = 5; c = SRC | MW | SHF; end
            6'h10: begin
               if (m == 0) c = MFC | RW;
               else if (m == 4) c = MTC;
               else if (m == 5'h10 && f == 6'h18) c = ERT;
            end
            default: ;
         endcase
      end
      return {a[3:0], c[18:0]};
   endfunction

   task automatic ref_alu(input logic [3:0] o,
                          input logic [31:0] x,
                          input logic [31:0] y,
                          output logic [31:0] r1,
                          output logic [31:0] r2);
      int ix = int'(x);
      int iy = int'(y);
      longint sx = ix;
      longint sy = iy;
      longint unsigned ux = x;
      longint unsigned uy = y;
      longint unsigned lr;
      longint p, q, rm;
      int s = int'(y & 32'h1F);
      r1 = 0;
      r2 = 0;
      case (o)
         0: begin lr = ux << s; r1 = lr[31:0]; end
         1: r1 = ix >>> s;
         2: r1 = x >> s;
`ifdef ALU_MULDIV_EN
         3: begin
            p = sx * sy;
            r1 = p[31:0];
            r2 = p[63:32];
         end
         4: if (sy != 0) begin
            q  = sx / sy;
            rm = sx % sy;
            r1 = q[31:0];
            r2 = rm[31:0];
         end
`endif
         5: begin lr = ux + uy; r1 = lr[31:0]; end
         6: begin lr = ux - uy; r1 = lr[31:0]; end
         7:  r1 = x & y;
         8:  r1 = x | y;
         9:  r1 = x ^ y;
         10: r1 = ~(x | y);
         11: r1 = (ix < iy) ? 1 : 0;
         12: r1 = (ux < uy) ? 1 : 0;
         default: ;
      endcase
   endtask

   task automatic alu_chk(input string tag,
                          input logic [3:0] o,
                          input logic [31:0] x,
                          input logic [31:0] y);
      logic [31:0] e1, e2;
      alu_op = o;
      alu_x  = x;
      alu_y  = y;
      #1;
      ref_alu(o, x, y, e1, e2);
      check({tag, "_r1"}, alu_r1, e1);
      check({tag, "_r2"}, alu_r2, e2);
      check({tag, "_eq"}, {31'b0, alu_eq},
            {31'b0, x == y});
   endtask

   // one clock of RAM traffic; read checked before the edge
   task automatic ram_cycle(input logic r,
                            input logic w,
                            input logic [9:0] a,
                            input logic [31:0] d);
      @(negedge clk);
      rst = r;
      ram_we = w;
      ram_addr = a;
      ram_din = d;
      #1;
      if (!r) check("ram_rd", ram_dout, mdl[a]);
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 1024; i++) mdl[i] = '0;
      end else if (w) begin
         mdl[a] = d;
      end
      #1;
   endtask

   logic [5:0] ops [22] = '{
      6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
      6'h06, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
      6'h0E, 6'h0F, 6'h10, 6'h10, 6'h23, 6'h2B, 6'h29,
      6'h3F};
   logic [5:0] fns [18] = '{
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
      6'h0C, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
      6'h26, 6'h27, 6'h2A, 6'h2B};
   logic [4:0] mfs [4] = '{5'h00, 5'h04, 5'h10, 5'h01};

   initial begin
      logic [22:0] e;
      logic [31:0] vals [8] = '{
         32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
         32'h7FFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h1234};
      rst = 0; ram_we = 0; ram_addr = 0; ram_din = 0;
      op = 0; funct = 0; mf = 0;
      alu_op = 0; alu_x = 0; alu_y = 0;

      // reset with a competing write
      ram_cycle(1'b1, 1'b1, 10'd3, 32'h55);
      @(negedge clk);
      rst = 0; ram_we = 0;
      for (int i = 0; i < 6; i++) begin
         ram_addr = (i == 0) ? 10'd3 : 10'($urandom);
         #1;
         check("rst_zero", ram_dout, 32'h0);
      end

      // write visible only after the edge
      ram_cycle(1'b0, 1'b1, 10'd3, 32'hDEADBEEF);
      ram_cycle(1'b0, 1'b0, 10'd3, 32'h0);
      check("wr_after", mdl[3], 32'hDEADBEEF);

      for (int i = 0; i < 400; i++) begin
         ram_cycle($urandom_range(0, 60) == 0,
                   1'($urandom),
                   ($urandom_range(0, 1) != 0)
                      ? 10'($urandom_range(0, 15))
                      : 10'($urandom),
                   $urandom);
      end
      @(negedge clk);
      rst = 0; ram_we = 0;

      // decode directed
      op = 6'h08; funct = 0; mf = 0; #1;
      check("dec_addi_ctr", {13'b0, ctr}, 32'h42);
      check("dec_addi_aop", {28'b0, ctr_aluop}, 32'd5);
      op = 6'h2B; #1;
      check("dec_sw_ctr", {13'b0, ctr}, 32'h50);
      check("dec_sw_aop", {28'b0, ctr_aluop}, 32'd5);
      op = 6'h3F; #1;
      check("dec_bad_ctr", {13'b0, ctr}, 32'h0);
      check("dec_bad_aop", {28'b0, ctr_aluop}, 32'h0);

      // decode random
      for (int i = 0; i < 300; i++) begin
         op = ($urandom_range(0, 4) == 0)
            ? 6'($urandom) : ops[$urandom_range(0, 21)];
         funct = ($urandom_range(0, 4) == 0)
            ? 6'($urandom) : fns[$urandom_range(0, 17)];
         if (op == 6'h10 && $urandom_range(0, 1) != 0)
            funct = 6'h18;
         mf = ($urandom_range(0, 4) == 0)
            ? 5'($urandom) : mfs[$urandom_range(0, 3)];
         #1;
         e = ref_dec(op, funct, mf);
         check("dec_ctr", {13'b0, ctr}, {13'b0, e[18:0]});
         check("dec_aop", {28'b0, ctr_aluop},
               {28'b0, e[22:19]});
      end

      // ALU directed
      alu_chk("sub", 4'd6, 32'd5, 32'd7);
      check("sub_val", alu_r1, 32'hFFFFFFFE);
      alu_chk("slt", 4'd11, 32'hFFFFFFFF, 32'd1);
      check("slt_val", alu_r1, 32'd1);
      alu_chk("sltu", 4'd12, 32'hFFFFFFFF, 32'd1);
      check("sltu_val", alu_r1, 32'd0);
      alu_chk("eq", 4'd15, 32'h1234, 32'h1234);
      check("eq_val", {31'b0, alu_eq}, 32'd1);
      alu_chk("sra", 4'd1, 32'h80000000, 32'd4);
      check("sra_val", alu_r1, 32'hF8000000);
      alu_chk("srl", 4'd2, 32'h80000000, 32'd4);
      check("srl_val", alu_r1, 32'h08000000);
      alu_chk("sll", 4'd0, 32'd1, 32'h21);
      check("sll_val", alu_r1, 32'd2);
      alu_chk("mul", 4'd3, 32'd7, 32'hFFFFFFFD);
      alu_chk("div", 4'd4, 32'hFFFFFFF9, 32'd2);
      alu_chk("div0", 4'd4, 32'd9, 32'd0);
      alu_chk("divmin", 4'd4, 32'h80000000, 32'hFFFFFFFF);
`ifdef ALU_MULDIV_EN
      alu_chk("mulv", 4'd3, 32'd7, 32'hFFFFFFFD);
      check("mul_lo", alu_r1, 32'hFFFFFFEB);
      check("mul_hi", alu_r2, 32'hFFFFFFFF);
      alu_chk("divv", 4'd4, 32'hFFFFFFF9, 32'd2);
      check("div_q", alu_r1, 32'hFFFFFFFD);
      check("div_r", alu_r2, 32'hFFFFFFFF);
`else
      alu_chk("mulv", 4'd3, 32'd7, 32'hFFFFFFFD);
      check("mul_off", alu_r1 | alu_r2, 32'h0);
`endif
      alu_chk("div0v", 4'd4, 32'd9, 32'd0);
      check("div0_q", alu_r1, 32'h0);
      check("div0_r", alu_r2, 32'h0);

      // ALU random
      for (int i = 0; i < 400; i++) begin
         logic [31:0] x, y;
         x = ($urandom_range(0, 2) == 0)
            ? vals[$urandom_range(0, 7)] : $urandom;
         case ($urandom_range(0, 3))
            0: y = x;
            1: y = vals[$urandom_range(0, 7)];
            2: y = 32'($urandom_range(0, 40));
            default: y = $urandom;
         endcase
         alu_chk("alu_rnd", 4'($urandom), x, y);
      end

      // reset priority at the end of the run
      ram_cycle(1'b0, 1'b1, 10'd3, 32'hA5A5A5A5);
      ram_cycle(1'b1, 1'b1, 10'd3, 32'h55);
      @(negedge clk);
      rst = 0; ram_we = 0; ram_addr = 10'd3;
      #1;
      check("rst_prio", ram_dout, 32'h0);

      $display("Result: errors=%0d of %0d checks",
               errs, checks);
      $finish;
   end

endmodule
